// File: rtl/conv_host_mem_pkg.sv
// -----------------------------------------------------------------------------
// conv_host_mem_pkg
// Shared constants and types for the CONV host-side memory responder:
// data/address widths, L1 (max-pool) depth, layer-select codes, FSM states,
// and a helper that range-checks an address against the L1 depth.
// -----------------------------------------------------------------------------
package conv_host_mem_pkg;

  localparam int DW        = 20;
  localparam int AW        = 12;
  localparam int IMG_DEPTH = 1 << AW;
  localparam int L1_DEPTH  = 1024;
  localparam int L1_AW     = $clog2(L1_DEPTH);

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // L1 is smaller than the address space; anything at or above its depth is
  // treated as nonexistent rather than wrapped.
  function automatic logic l1_in_range(input logic [AW-1:0] addr);
    return addr < AW'(L1_DEPTH);
  endfunction

endpackage

// File: rtl/conv_host_mem_if.sv
// -----------------------------------------------------------------------------
// conv_host_mem_if
// CONV engine <-> host memory bus.
//   master : CONV engine side (drives busy, image/layer addresses, strobes)
//   slave  : memory responder side (drives ready, idata, cdata_rd)
// Signals: ready, busy, iaddr, idata, cwr, caddr_wr, cdata_wr,
//          crd, caddr_rd, cdata_rd, csel
// -----------------------------------------------------------------------------
interface conv_host_mem_if;
  import conv_host_mem_pkg::*;

  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

endinterface

// File: rtl/conv_host_mem_layer_ram.sv
// -----------------------------------------------------------------------------
// conv_layer_ram
// Simple RAM: one synchronous write port, NRD asynchronous read ports.
// Reads return the stored word in the same cycle, so a read and a write to
// the same word in one cycle observe the pre-write contents.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read addresses  [NRD]
//   rdata  out  read data       [NRD]
// -----------------------------------------------------------------------------
module conv_layer_ram #(
  parameter int DEPTH  = 4096,
  parameter int WIDTH  = 20,
  parameter int NRD    = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr [NRD],
  output logic [WIDTH-1:0]  rdata [NRD]
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end

endmodule

// File: rtl/conv_host_mem.sv
// -----------------------------------------------------------------------------
// conv_host_mem
// Host-side responder for the CONV engine. Owns the image RAM and the L0/L1
// result RAMs. The host loads the image while idle and pulses start; the
// block then raises ready, serves image and layer traffic while CONV is busy,
// and reports which layers were written once busy falls (or a timeout hits).
// Ports:
//   clk, reset (async, active-low)
//   start, img_we/img_addr/img_wdata       host control and image load
//   rb_en/rb_sel/rb_addr -> rb_rdata       host readback (registered)
//   done, timeout, l0_written, l1_written  status
//   bus (conv_host_mem_if.slave)           CONV engine bus
// -----------------------------------------------------------------------------
module conv_host_mem
  import conv_host_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            img_we,
  input  logic [AW-1:0]   img_addr,
  input  logic [DW-1:0]   img_wdata,
  input  logic            rb_en,
  input  logic [2:0]      rb_sel,
  input  logic [AW-1:0]   rb_addr,
  output logic [DW-1:0]   rb_rdata,
  output logic            done,
  output logic            timeout,
  output logic            l0_written,
  output logic            l1_written,
  conv_host_mem_if.slave  bus
);

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic        ready_q;
  logic [31:0] cyc_cnt;
  logic [DW-1:0] cdata_hold;

  // RAM port wiring
  logic          img_we_g;
  logic [AW-1:0] img_raddr [1];
  logic [DW-1:0] img_rdata [1];

  logic          l0_we;
  logic [AW-1:0] l0_raddr [2];
  logic [DW-1:0] l0_rdata [2];

  logic             l1_we;
  logic [L1_AW-1:0] l1_raddr [2];
  logic [DW-1:0]    l1_rdata [2];

  logic          run_wr;
  logic [DW-1:0] conv_rd_word;
  logic [DW-1:0] rb_word;

  // Image load is only accepted from the host while idle.
  assign img_we_g     = img_we && (state == ST_IDLE);
  assign img_raddr[0] = bus.iaddr;

  assign run_wr = bus.cwr && (state == ST_RUN);
  assign l0_we  = run_wr && (bus.csel == CSEL_L0);
  assign l1_we  = run_wr && (bus.csel == CSEL_L1) && l1_in_range(bus.caddr_wr);

  // Port 0 serves CONV reads, port 1 serves host readback.
  assign l0_raddr[0] = bus.caddr_rd;
  assign l0_raddr[1] = rb_addr;
  assign l1_raddr[0] = bus.caddr_rd[L1_AW-1:0];
  assign l1_raddr[1] = rb_addr[L1_AW-1:0];

  conv_layer_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW), .NRD(1)) u_img_ram (
    .clk   (clk),
    .we    (img_we_g),
    .waddr (img_addr),
    .wdata (img_wdata),
    .raddr (img_raddr),
    .rdata (img_rdata)
  );

  conv_layer_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW), .NRD(2)) u_l0_ram (
    .clk   (clk),
    .we    (l0_we),
    .waddr (bus.caddr_wr),
    .wdata (bus.cdata_wr),
    .raddr (l0_raddr),
    .rdata (l0_rdata)
  );

  conv_layer_ram #(.DEPTH(L1_DEPTH), .WIDTH(DW), .NRD(2)) u_l1_ram (
    .clk   (clk),
    .we    (l1_we),
    .waddr (bus.caddr_wr[L1_AW-1:0]),
    .wdata (bus.cdata_wr),
    .raddr (l1_raddr),
    .rdata (l1_rdata)
  );

  // Layer read muxes: unknown select or out-of-range L1 address reads as 0.
  always_comb begin
    conv_rd_word = '0;
    if (bus.csel == CSEL_L0)
      conv_rd_word = l0_rdata[0];
    else if ((bus.csel == CSEL_L1) && l1_in_range(bus.caddr_rd))
      conv_rd_word = l1_rdata[0];
  end

  always_comb begin
    rb_word = '0;
    if (rb_sel == CSEL_L0)
      rb_word = l0_rdata[1];
    else if ((rb_sel == CSEL_L1) && l1_in_range(rb_addr))
      rb_word = l1_rdata[1];
  end

  assign bus.ready    = ready_q;
  assign bus.idata    = ((state == ST_RUN) && bus.busy && !ready_q) ? img_rdata[0] : '0;
  // With crd low the CONV side keeps seeing the last word it read.
  assign bus.cdata_rd = bus.crd ? conv_rd_word : cdata_hold;

  // Run control FSM, cycle counter and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      l0_written <= 1'b0;
      l1_written <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (l0_we) l0_written <= 1'b1;
      if (l1_we) l1_written <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ARM;
            ready_q    <= 1'b1;
            timeout    <= 1'b0;
            l0_written <= 1'b0;
            l1_written <= 1'b0;
            cyc_cnt    <= '0;
          end
        end
        ST_ARM, ST_RUN: begin
          // Timeout wins over any handshake progress in the same cycle.
          if (cyc_cnt == CNT_LAST) begin
            state   <= ST_DONE;
            ready_q <= 1'b0;
            timeout <= 1'b1;
            done    <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (state == ST_ARM) begin
              if (bus.busy) begin
                state   <= ST_RUN;
                ready_q <= 1'b0;
              end
            end else if (!bus.busy) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-side data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_rdata   <= '0;
      cdata_hold <= '0;
    end else begin
      if (rb_en)   rb_rdata   <= rb_word;
      if (bus.crd) cdata_hold <= conv_rd_word;
    end
  end

endmodule
